// File: rtl/spi_pkg.sv
// Shared definitions for the single-frame SPI slave: default frame width,
// bit-counter sizing and the frame-control state encoding.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH  = $clog2(DEFAULT_DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spiState_e;

    // The counter must be able to hold the value DATA_WIDTH itself.
    function automatic int cntWidth(input int dataWidth);
        return $clog2(dataWidth + 1);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Byte-side and serial-side signals of the SPI slave, bundled with
// modports for the slave itself and for whoever drives the frame.
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  CS;
    logic                  MOSI;
    logic [DATA_WIDTH-1:0] slaveDataToSend;
    logic [DATA_WIDTH-1:0] slaveDataReceived;

    modport slave (
        input  CS,
        input  MOSI,
        input  slaveDataToSend,
        output slaveDataReceived
    );

    modport master (
        output CS,
        output MOSI,
        output slaveDataToSend,
        input  slaveDataReceived
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Parameterised shift register with parallel load (priority over shift),
// clocked on either SCLK edge, with asynchronous active-low reset.
module spi_shift_reg #(
    parameter int WIDTH    = 8,
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadEn,
    input  logic [WIDTH-1:0] loadData,
    input  logic             shiftEn,
    input  logic             shiftIn,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] nextQ;

    always_comb begin
        nextQ = q;
        if (loadEn) begin
            nextQ = loadData;
        end else if (shiftEn) begin
            nextQ = {q[WIDTH-2:0], shiftIn};
        end
    end

    generate
        if (NEG_EDGE) begin : gNegEdge
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else begin
                    q <= nextQ;
                end
            end
        end else begin : gPosEdge
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else begin
                    q <= nextQ;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave clocked by SCLK: shifts one DATA_WIDTH frame in and out
// per CS-low period and publishes the received word after the last bit.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic        SCLK,
    input  logic        reset,
    spi_slave_if.slave  bus,
    output logic        MISO
);

    localparam int             CW       = cntWidth(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  FULL     = CW'(DATA_WIDTH);

    spiState_e             state;
    logic [CW-1:0]         bitCnt;
    logic [DATA_WIDTH-1:0] rxData;
    logic [DATA_WIDTH-1:0] rxShift;
    logic [DATA_WIDTH-1:0] txShift;
    logic                  rxShiftEn;
    logic                  txShiftEn;
    logic                  unusedBits;

    assign rxShiftEn = !bus.CS && (state != DONE);
    assign txShiftEn = !bus.CS && (bitCnt != '0) && (bitCnt < FULL);

    spi_shift_reg #(
        .WIDTH    (DATA_WIDTH),
        .NEG_EDGE (1'b0)
    ) rxReg (
        .clk      (SCLK),
        .reset    (reset),
        .loadEn   (1'b0),
        .loadData ('0),
        .shiftEn  (rxShiftEn),
        .shiftIn  (bus.MOSI),
        .q        (rxShift)
    );

    // Loaded on falling edges while CS is high, so the MSB is already on
    // MISO when CS drops with SCLK idle low.
    spi_shift_reg #(
        .WIDTH    (DATA_WIDTH),
        .NEG_EDGE (1'b1)
    ) txReg (
        .clk      (SCLK),
        .reset    (reset),
        .loadEn   (bus.CS),
        .loadData (bus.slaveDataToSend),
        .shiftEn  (txShiftEn),
        .shiftIn  (1'b0),
        .q        (txShift)
    );

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            bitCnt <= '0;
            rxData <= '0;
        end else if (bus.CS) begin
            state  <= IDLE;
            bitCnt <= '0;
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    bitCnt <= bitCnt + CW'(1);
                    if (bitCnt == LAST_BIT) begin
                        state  <= DONE;
                        rxData <= {rxShift[DATA_WIDTH-2:0], bus.MOSI};
                    end else begin
                        state  <= SHIFT;
                    end
                end
                default: begin
                    // DONE: every further edge is ignored until CS rises.
                end
            endcase
        end
    end

    assign bus.slaveDataReceived = rxData;
    assign MISO = bus.CS ? 1'bz : txShift[DATA_WIDTH-1];

    // Bits of the shift registers that are only consumed inside spi_shift_reg.
    assign unusedBits = ^{rxShift[DATA_WIDTH-1], txShift[DATA_WIDTH-2:0]};

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as a mode-0 SPI master, scoreboards
// expected slave/master bytes per frame and checks with immediate assertions.
module tb_spi_slave;

    typedef struct packed {
        logic [7:0] slaveExp;
        logic [7:0] masterExp;
    } frameExp_t;

    logic SCLK;
    logic reset;
    wire  MISO;

    int vectors;
    int miscompares;

    frameExp_t sb[$];
    frameExp_t e;
    logic [7:0] got;
    logic       b;
    logic       misoHold;

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave #(.DATA_WIDTH(8)) dut (
        .SCLK  (SCLK),
        .reset (reset),
        .bus   (bus),
        .MISO  (MISO)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full SCLK cycle with CS high, then CS drops with SCLK low.
    task automatic idleLoad(input logic [7:0] d);
        bus.CS = 1'b1;
        bus.slaveDataToSend = d;
        #5 SCLK = 1'b1;
        #5 SCLK = 1'b0;
        #5 bus.CS = 1'b0;
        #5;
    endtask

    task automatic shiftBit(input logic mosiBit, output logic misoBit);
        bus.MOSI = mosiBit;
        #4 misoBit = MISO;
        #1 SCLK = 1'b1;
        #5 SCLK = 1'b0;
        #5;
    endtask

    task automatic runFrame(input logic [7:0] d, input logic [7:0] m, input int nbits,
                            output logic [7:0] cap);
        logic bit_v;
        cap = 8'h00;
        idleLoad(d);
        for (int i = 0; i < nbits; i++) begin
            shiftBit(m[7-i], bit_v);
            cap[7-i] = bit_v;
        end
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] cap);
        e = sb.pop_front();
        check({tag, "_slave"},  bus.slaveDataReceived, e.slaveExp);
        check({tag, "_master"}, cap, e.masterExp);
    endtask

    initial begin
        logic [7:0] txTab [3];
        logic [7:0] rxTab [3];
        vectors     = 0;
        miscompares = 0;
        SCLK  = 1'b0;
        reset = 1'b1;
        bus.CS = 1'b1;
        bus.MOSI = 1'b0;
        bus.slaveDataToSend = 8'h80;

        // Reset held with CS high: loads are blocked, output stays cleared.
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #5 SCLK = 1'b1;
            #5 SCLK = 1'b0;
        end
        #2;
        check("rst_rx", bus.slaveDataReceived, 8'h00);
        check("rst_miso_hiz", {7'd0, (MISO === 1'bz) || (MISO === 1'b0)}, 8'h01);
        #3 reset = 1'b1;
        #5;

        // Frame 1 with a latency check before the final rising edge.
        sb.push_back('{slaveExp: 8'h53, masterExp: 8'h09});
        runFrame(8'h09, 8'h53, 7, got);
        check("f1_latency", bus.slaveDataReceived, 8'h00);
        shiftBit(1'b1, b);
        got[0] = b;
        checkFrame("f1", got);

        txTab = '{8'h98, 8'h6A, 8'hD7};
        rxTab = '{8'h3C, 8'hD7, 8'hBA};
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{slaveExp: rxTab[k], masterExp: txTab[k]});
            runFrame(txTab[k], rxTab[k], 8, got);
            checkFrame($sformatf("f%0d", k + 2), got);
        end

        // Over-clocking: after the last bit MISO shows the sent byte's LSB.
        for (int i = 0; i < 20; i++) begin
            shiftBit(i[0], misoHold);
            check($sformatf("ovr_rx%0d", i), bus.slaveDataReceived, 8'hBA);
            check($sformatf("ovr_miso%0d", i), {7'd0, misoHold}, {7'd0, txTab[2][0]});
        end

        // CS high with an all-ones byte loaded: MISO must not be driven high.
        bus.CS = 1'b1;
        bus.slaveDataToSend = 8'hFF;
        #5 SCLK = 1'b1;
        #5 SCLK = 1'b0;
        #2;
        check("cs_high_miso_hiz", {7'd0, (MISO === 1'bz) || (MISO === 1'b0)}, 8'h01);
        #3;

        // Abort after 5 bits, then a full frame.
        runFrame(8'h66, 8'h5A, 5, got);
        bus.CS = 1'b1;
        #5;
        check("abort_hold", bus.slaveDataReceived, 8'hBA);
        sb.push_back('{slaveExp: 8'hA5, masterExp: 8'h3C});
        runFrame(8'h3C, 8'hA5, 8, got);
        checkFrame("post_abort", got);

        // Reset mid-frame: 0x0F shifted four times puts a 1 on MISO.
        runFrame(8'h0F, 8'h12, 4, got);
        check("mid_pre_miso", {7'd0, MISO}, 8'h01);
        reset = 1'b0;
        #1;
        check("mid_rst_rx", bus.slaveDataReceived, 8'h00);
        check("mid_rst_miso", {7'd0, MISO}, 8'h00);
        #4 reset = 1'b1;
        #5;
        sb.push_back('{slaveExp: 8'h81, masterExp: 8'hC3});
        runFrame(8'hC3, 8'h81, 8, got);
        checkFrame("post_rst", got);

        bus.CS = 1'b1;
        #10;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Single-byte SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) clocked directly by the serial clock SCLK. While chip-select CS is low it shifts out the byte presented on `slaveDataToSend` on MISO and shifts in the byte arriving on MOSI. After exactly 8 bits it publishes the received byte on `slaveDataReceived`. It sits at the chip boundary between an external SPI master and on-chip logic that supplies and consumes byte-wide data.

## Interface
- `DATA_WIDTH`, default 8: frame length in bits. All port widths and counters scale with it; the test plan uses 8.
- `SCLK`, input, 1: serial clock and the block's only clock. Idles low.
- `reset`, input, 1: asynchronous, active-low reset.
- `slaveDataToSend`, input, DATA_WIDTH: byte to transmit. Sampled while CS is high.
- `slaveDataReceived`, output, DATA_WIDTH: last completely received byte. Registered.
- `CS`, input, 1: chip select, active-low. Frames a transfer.
- `MOSI`, input, 1: serial data from the master.
- `MISO`, output, 1: serial data to the master. High-impedance while CS is high.

## Operation
Internal state:
- `tx_shift` (DATA_WIDTH)
- `rx_shift` (DATA_WIDTH)
- `bit_cnt` (0..DATA_WIDTH)
- `done` flag

State machine:
- IDLE (CS=1): on each SCLK rising edge, load `tx_shift` from `slaveDataToSend`, clear `bit_cnt` and `done`. The last value loaded before CS falls is the value transmitted.
- SHIFT (CS=0, `done`=0):
  - SCLK rising edge: `rx_shift` ← {`rx_shift`[W-2:0], MOSI}; `bit_cnt`++.
  - SCLK falling edge: when 1 ≤ `bit_cnt` < W, `tx_shift` ← {`tx_shift`[W-2:0], 0}.
- DONE: on the rising edge where `bit_cnt` reaches W:
  - `slaveDataReceived` ← {`rx_shift`[W-2:0], MOSI}.
  - Set `done`.
  - All further SCLK edges are ignored until CS returns high. Extra clocks cause no shifting and no output change.
- MISO = `tx_shift`[W-1] whenever CS=0; 1'bz whenever CS=1.
- Aborted frame (CS rises before W bits): discard the partial `rx_shift`; `slaveDataReceived` keeps its previous value; return to IDLE.
- CS reasserted: a new frame needs at least one SCLK rising edge with CS high first, so `tx_shift` is reloaded.

## Timing
- Reset (`reset`=0, asynchronous, any time, including mid-frame):
  - `slaveDataReceived`=0, `tx_shift`=0, `rx_shift`=0, `bit_cnt`=0, `done`=0.
  - MISO follows CS as above.
  - Release is synchronous to the next SCLK edge.
- First MISO bit (MSB) is valid combinationally as soon as CS falls. Bit k is valid after the k-th falling edge.
- Master contract:
  - Drive MOSI before the SCLK rising edge.
  - Sample MISO on the rising edge.
  - Change MOSI after the falling edge.
- Latency: `slaveDataReceived` updates on the W-th SCLK rising edge after CS falls. It is stable from then until the next completed frame.
- CS and MOSI must be stable around SCLK rising edges. No metastability handling: SCLK is the clock domain.

## Structure
- Shared package `spi_pkg`: `DATA_WIDTH` default and the counter width `$clog2(DATA_WIDTH+1)`.
- One sub-module `spi_shift_reg`: parameterised shift register with load/shift enable and selectable edge. Instantiate twice (tx on the falling edge, rx on the rising edge).
- Control (`bit_cnt`, `done`, output register, MISO tri-state) stays in the top level.

## Test plan
- Reset: hold `reset`=0 with CS=1 → `slaveDataReceived`=0x00, MISO=z. Assert `reset`=0 mid-frame → all state cleared immediately.
- Frame 1: `slaveDataToSend`=0x09, master sends 0x53 MSB-first over 8 clocks → master captures 0x09, `slaveDataReceived`=0x53 after the 8th rising edge.
- Frames 2–4, back-to-back with CS pulsed high between them:
  - 0x3C/0x98 → master gets 0x98, slave gets 0x3C.
  - 0xD7/0x6A → master gets 0x6A, slave gets 0xD7.
  - 0xBA/0xD7 → master gets 0xD7, slave gets 0xBA.
- Over-clocking: keep CS low for 20 extra SCLK cycles after 8 bits with MOSI toggling → `slaveDataReceived` holds its value and MISO stays constant.
- Abort: raise CS after 5 bits, then run a full frame sending 0xA5 → output unchanged after the abort, 0xA5 after the full frame.
